// File: rtl/prei_md_ram_ctrl_if.sv
// Client/SRAM-side signal bundle for the pre-intra mode-decision store controller.
// slave = controller view, master = client + SRAM view.
interface prei_md_ram_ctrl_if #(
    parameter int ADR_WD = 7,
    parameter int DAT_WD = 6
);
    logic              clr_start_i;
    logic              clr_done_o;
    logic              wr_val_i;
    logic              wr_rdy_o;
    logic [1:0]        wr_dep_i;
    logic [5:0]        wr_idx_i;
    logic [DAT_WD-1:0] wr_md_i;
    logic              rd_val_i;
    logic              rd_rdy_o;
    logic [1:0]        rd_dep_i;
    logic [5:0]        rd_idx_i;
    logic              rd_dat_val_o;
    logic [DAT_WD-1:0] rd_md_o;
    logic              err_o;
    logic [ADR_WD-1:0] ram_adr_o;
    logic              ram_wr_ena_o;
    logic [DAT_WD-1:0] ram_wr_dat_o;
    logic              ram_rd_ena_o;
    logic [DAT_WD-1:0] ram_rd_dat_i;

    modport slave (
        input  clr_start_i, wr_val_i, wr_dep_i, wr_idx_i, wr_md_i,
               rd_val_i, rd_dep_i, rd_idx_i, ram_rd_dat_i,
        output clr_done_o, wr_rdy_o, rd_rdy_o, rd_dat_val_o, rd_md_o, err_o,
               ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o
    );

    modport master (
        output clr_start_i, wr_val_i, wr_dep_i, wr_idx_i, wr_md_i,
               rd_val_i, rd_dep_i, rd_idx_i, ram_rd_dat_i,
        input  clr_done_o, wr_rdy_o, rd_rdy_o, rd_dat_val_o, rd_md_o, err_o,
               ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o
    );
endinterface

// File: rtl/prei_md_ram_ctrl.sv
// Single-port SRAM controller for the 85-node LCU intra-mode store: 2-deep write FIFO,
// read/write arbitration and clear sweep. Define PREI_MD_FWD_EN to forward reads from the FIFO.
module prei_md_ram_ctrl #(
    parameter int                ADR_WD   = 7,
    parameter int                DAT_WD   = 6,
    parameter int                NODE_NUM = 85,
    parameter logic [DAT_WD-1:0] CLR_MD   = 1
) (
    input  logic                clk,
    input  logic                rst,
    prei_md_ram_ctrl_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [ADR_WD-1:0] LAST_ADR = ADR_WD'(NODE_NUM - 1);

    function automatic logic [ADR_WD-1:0] node_adr(input logic [1:0] dep, input logic [5:0] idx);
        logic [ADR_WD-1:0] base;
        case (dep)
            2'd0:    base = ADR_WD'(0);
            2'd1:    base = ADR_WD'(1);
            2'd2:    base = ADR_WD'(5);
            default: base = ADR_WD'(21);
        endcase
        return base + ADR_WD'(idx);
    endfunction

    // Depth d holds 4^d nodes; depth 3 covers the full 6-bit index range.
    function automatic logic node_ok(input logic [1:0] dep, input logic [5:0] idx);
        case (dep)
            2'd0:    return idx == 6'd0;
            2'd1:    return idx[5:2] == 4'd0;
            2'd2:    return idx[5:4] == 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    logic [1:0]                    state_q, state_d;
    logic [ADR_WD-1:0]             clr_adr_q, clr_adr_d;
    logic                          clr_done_q, clr_done_d;
    logic                          err_q, err_d;
    logic [1:0]                    cnt_q, cnt_d;
    logic [1:0][ADR_WD-1:0]        fifo_adr_q, fifo_adr_d;
    logic [1:0][DAT_WD-1:0]        fifo_md_q, fifo_md_d;
    logic                          rd_pend_q, rd_pend_d;
    logic                          fwd_vld_q, fwd_vld_d;
    logic [DAT_WD-1:0]             fwd_md_q, fwd_md_d;

    logic [ADR_WD-1:0] wr_adr, rd_adr;
    logic              wr_ok, rd_ok, clearing, full, m0, m1, hit;
    logic              wr_acc, rd_acc, push, pop, rd_issue, rd_fwd;

    assign wr_adr   = node_adr(bus.wr_dep_i, bus.wr_idx_i);
    assign rd_adr   = node_adr(bus.rd_dep_i, bus.rd_idx_i);
    assign wr_ok    = node_ok(bus.wr_dep_i, bus.wr_idx_i);
    assign rd_ok    = node_ok(bus.rd_dep_i, bus.rd_idx_i);
    assign clearing = (state_q == S_CLEAR);
    assign full     = (cnt_q == 2'd2);
    assign m0       = (cnt_q != 2'd0) && (fifo_adr_q[0] == rd_adr);
    assign m1       = full && (fifo_adr_q[1] == rd_adr);
    assign hit      = rd_ok & (m0 | m1);

    assign bus.wr_rdy_o = !rst && !clearing && !full;
`ifdef PREI_MD_FWD_EN
    assign bus.rd_rdy_o = !rst && !clearing && !full;
`else
    assign bus.rd_rdy_o = !rst && !clearing && !full && !hit;
`endif

    assign wr_acc   = bus.wr_val_i & bus.wr_rdy_o;
    assign rd_acc   = bus.rd_val_i & bus.rd_rdy_o;
    assign push     = wr_acc & wr_ok;
    assign rd_issue = rd_acc & rd_ok & !hit;
    assign rd_fwd   = rd_acc & hit;
    // The port drains the FIFO whenever no SRAM read claims it.
    assign pop      = !clearing && (cnt_q != 2'd0) && !rd_issue;

    always_comb begin
        bus.ram_adr_o    = '0;
        bus.ram_wr_ena_o = 1'b1;
        bus.ram_wr_dat_o = '0;
        bus.ram_rd_ena_o = 1'b1;
        if (rst) begin
            bus.ram_wr_ena_o = 1'b1;
        end else if (clearing) begin
            bus.ram_wr_ena_o = 1'b0;
            bus.ram_adr_o    = clr_adr_q;
            bus.ram_wr_dat_o = CLR_MD;
        end else if (rd_issue) begin
            bus.ram_rd_ena_o = 1'b0;
            bus.ram_adr_o    = rd_adr;
        end else if (pop) begin
            bus.ram_wr_ena_o = 1'b0;
            bus.ram_adr_o    = fifo_adr_q[0];
            bus.ram_wr_dat_o = fifo_md_q[0];
        end
    end

    always_comb begin
        fifo_adr_d = fifo_adr_q;
        fifo_md_d  = fifo_md_q;
        cnt_d      = cnt_q;
        if (pop) begin
            fifo_adr_d[0] = fifo_adr_q[1];
            fifo_md_d[0]  = fifo_md_q[1];
            cnt_d         = cnt_q - 2'd1;
        end
        if (push) begin
            fifo_adr_d[cnt_d[0]] = wr_adr;
            fifo_md_d[cnt_d[0]]  = bus.wr_md_i;
            cnt_d                = cnt_d + 2'd1;
        end
        if (bus.clr_start_i) cnt_d = 2'd0;
    end

    always_comb begin
        state_d    = state_q;
        clr_adr_d  = clr_adr_q;
        clr_done_d = 1'b0;
        if (bus.clr_start_i) begin
            state_d   = S_CLEAR;
            clr_adr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: if (wr_acc || rd_acc) state_d = S_RUN;
                S_RUN: if (cnt_q == 2'd0 && !rd_pend_q && !fwd_vld_q && !wr_acc && !rd_acc)
                    state_d = S_IDLE;
                S_CLEAR: begin
                    clr_adr_d = clr_adr_q + ADR_WD'(1);
                    if (clr_adr_q == LAST_ADR) begin
                        state_d    = S_IDLE;
                        clr_adr_d  = '0;
                        clr_done_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign err_d     = bus.clr_start_i ? 1'b0 : (err_q | (wr_acc & !wr_ok) | (rd_acc & !rd_ok));
    assign rd_pend_d = rd_issue;
    assign fwd_vld_d = rd_fwd;
    assign fwd_md_d  = m1 ? fifo_md_q[1] : fifo_md_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clr_adr_q  <= '0;
            clr_done_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 2'd0;
            fifo_adr_q <= '0;
            fifo_md_q  <= '0;
            rd_pend_q  <= 1'b0;
            fwd_vld_q  <= 1'b0;
            fwd_md_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_adr_q  <= clr_adr_d;
            clr_done_q <= clr_done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            fifo_adr_q <= fifo_adr_d;
            fifo_md_q  <= fifo_md_d;
            rd_pend_q  <= rd_pend_d;
            fwd_vld_q  <= fwd_vld_d;
            fwd_md_q   <= fwd_md_d;
        end
    end

    // Response follows the SRAM's one-cycle read latency; reset suppresses it at once.
    assign bus.rd_dat_val_o = !rst && (rd_pend_q || fwd_vld_q);
    assign bus.rd_md_o      = rst       ? '0 :
                              rd_pend_q ? bus.ram_rd_dat_i :
                              fwd_vld_q ? fwd_md_q : '0;
    assign bus.clr_done_o   = clr_done_q;
    assign bus.err_o        = err_q;
endmodule
